// File: rtl/aes_pkg.sv
// Shared AES core definitions: controller state encoding and AES-128 sizing constants.
package aes_pkg;

    localparam int unsigned AES_NR = 10;
    localparam int unsigned AES_RW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for the iterative AES-128 core: accepts a block, drives key
// expansion through load/run, steps the round datapath, then holds the result.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR,
    parameter int unsigned RW = AES_RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ke_rst,
    output logic          ke_done,
    output logic          in_fire,
    output logic          st_en,
    output logic [RW-1:0] round,
    output logic          first_round,
    output logic          last_round,
    output logic          busy
);

    ctrl_state_t   state;
    ctrl_state_t   nx_state;
    logic [RW-1:0] nx_round;

    // Request handshake; a new block is only taken once the old result is consumed
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign in_fire  = in_valid && in_ready;

    // Next state and next round index; the round stops at NR because RUN leaves at NR
    always_comb begin
        nx_state = state;
        nx_round = round;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    nx_state = LOAD;
                    nx_round = '0;
                end
            end
            LOAD: begin
                nx_state = RUN;
                nx_round = '0;
            end
            RUN: begin
                if (round == RW'(NR)) begin
                    nx_state = HOLD;
                end else begin
                    nx_round = round + RW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    nx_state = in_fire ? LOAD : IDLE;
                    nx_round = '0;
                end
            end
            default: begin
                nx_state = IDLE;
                nx_round = '0;
            end
        endcase
    end

    // State, round counter and registered output decodes of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            round       <= '0;
            out_valid   <= 1'b0;
            ke_rst      <= 1'b0;
            ke_done     <= 1'b1;
            st_en       <= 1'b0;
            busy        <= 1'b0;
            first_round <= 1'b0;
            last_round  <= 1'b0;
        end else begin
            state       <= nx_state;
            round       <= nx_round;
            out_valid   <= (nx_state == HOLD);
            ke_rst      <= (nx_state == LOAD);
            ke_done     <= (nx_state == IDLE) || (nx_state == HOLD);
            st_en       <= (nx_state == RUN);
            busy        <= (nx_state != IDLE);
            first_round <= (nx_state == RUN) && (nx_round == '0);
            last_round  <= (nx_state == RUN) && (nx_round == RW'(NR));
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed self-checking bench for aes_round_ctrl.
module tb_aes_round_ctrl;

    localparam int unsigned RW = 4;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_HOLD = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          ke_rst;
    logic          ke_done;
    logic          in_fire;
    logic          st_en;
    logic [RW-1:0] round;
    logic          first_round;
    logic          last_round;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    aes_round_ctrl #(.NR(10), .RW(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ke_rst      (ke_rst),
        .ke_done     (ke_done),
        .in_fire     (in_fire),
        .st_en       (st_en),
        .round       (round),
        .first_round (first_round),
        .last_round  (last_round),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {busy,out_valid,ke_rst,ke_done,st_en,first_round,last_round,round} per phase
    task automatic chk_phase(input string tag, input int ph, input int rnd);
        logic [10:0] exp;
        logic [10:0] obs;
        case (ph)
            P_IDLE:  exp = {7'b0001000, 4'd0};
            P_LOAD:  exp = {7'b1010000, 4'd0};
            P_RUN:   exp = {5'b10001, rnd == 0, rnd == 10, 4'(rnd)};
            default: exp = {7'b1101000, 4'd10};
        endcase
        obs = {busy, out_valid, ke_rst, ke_done, st_en, first_round, last_round, round};
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // Fire a request from IDLE (or HOLD with out_ready) and follow it to HOLD
    task automatic accept_and_run(input string tag, output int lat);
        int start;
        in_valid = 1'b1;
        #1;
        chk({tag, "_fire"}, 32'(in_fire), 32'd1);
        start = cyc;
        tick();
        in_valid = 1'b0;
        chk_phase({tag, "_load"}, P_LOAD, 0);
        chk({tag, "_ready_load"}, 32'(in_ready), 32'd0);
        for (int r = 0; r <= 10; r++) begin
            tick();
            chk_phase($sformatf("%s_run%0d", tag, r), P_RUN, r);
        end
        tick();
        chk_phase({tag, "_hold"}, P_HOLD, 10);
        lat = cyc - start;
    endtask

    initial begin
        int lat;
        int fires;
        int fire_cyc0;
        int fire_cyc1;
        logic seen_ov;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b1;
        #1;
        chk("rst_in_fire", 32'(in_fire), 32'd1);
        in_valid = 1'b0;
        #1;
        chk("rst_in_fire_lo", 32'(in_fire), 32'd0);
        tick();
        reset = 1'b0;
        cyc = 0;
        chk_phase("rst_outs", P_IDLE, 0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single block, request pulsed at cycle 5
        while (cyc < 5) tick();
        accept_and_run("single", lat);
        chk("single_lat", 32'(lat), 32'd13);
        chk("single_hold_cyc", 32'(cyc), 32'd18);
        chk("single_hold_ready", 32'(in_ready), 32'd1);
        tick();
        chk_phase("single_idle", P_IDLE, 0);

        // Backpressure: result held for 20 cycles, requests ignored
        out_ready = 1'b0;
        accept_and_run("bp", lat);
        chk("bp_lat", 32'(lat), 32'd13);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'(i % 2);
            #1;
            chk_phase($sformatf("bp_hold%0d", i), P_HOLD, 10);
            chk($sformatf("bp_ready%0d", i), 32'({in_ready, in_fire}), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk_phase("bp_hold_end", P_HOLD, 10);

        // Back-to-back: consume and accept in the same HOLD cycle
        out_ready = 1'b1;
        accept_and_run("b2b", lat);
        chk("b2b_ov_gap", 32'(lat), 32'd13);
        tick();
        chk_phase("b2b_idle", P_IDLE, 0);

        // Reset at round 4 discards the block
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_phase("mid_run4", P_RUN, 4);
        reset = 1'b1;
        tick();
        chk_phase("mid_rst_idle", P_IDLE, 0);
        reset = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_ov = seen_ov | out_valid | busy;
        end
        chk("mid_no_ov", 32'(seen_ov), 32'd0);
        accept_and_run("after_rst", lat);
        chk("after_rst_lat", 32'(lat), 32'd13);
        tick();
        chk_phase("after_rst_idle", P_IDLE, 0);

        // Continuous in_valid: one acceptance every 13 cycles
        in_valid  = 1'b1;
        fires     = 0;
        fire_cyc0 = -1;
        fire_cyc1 = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            chk($sformatf("cont_fire_busy%0d", i), 32'(in_fire & busy & ~out_valid), 32'd0);
            if (in_fire) begin
                if (fires == 0) fire_cyc0 = i;
                if (fires == 1) fire_cyc1 = i;
                fires++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("cont_fires", 32'(fires), 32'd4);
        chk("cont_gap", 32'(fire_cyc1 - fire_cyc0), 32'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES-128 encryption core. It accepts one block request per handshake and drives the 4-words-per-cycle key expansion unit through its load and run phases. It steps the shared round datapath through the initial AddRoundKey, rounds 1–9 and the final round, then holds the result until the consumer takes it. It sits between the core's request/response ports and the keyexpansion/round datapath, and holds no data itself.

## Interface
- `NR`, default 10: number of cipher rounds; only 10 (AES-128) is supported.
- `RW`, default 4: round index width; must satisfy `2**RW > NR`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  request present; key/plaintext valid on the datapath inputs
- `in_ready`  out  1  controller can accept a request
- `out_valid`  out  1  ciphertext in the datapath state register is final
- `out_ready`  in  1  consumer takes the ciphertext
- `ke_rst`  out  1  drives the key expansion reset; loads the key
- `ke_done`  out  1  freezes key expansion output at the last block
- `in_fire`  out  1  `in_valid & in_ready`; datapath captures key and plaintext
- `st_en`  out  1  state register update enable
- `round`  out  RW  current round index, 0..NR
- `first_round`  out  1  `round==0`; AddRoundKey only
- `last_round`  out  1  `round==NR`; bypass MixColumns
- `busy`  out  1  state ≠ IDLE

## Operation
- State machine with four states: IDLE, LOAD, RUN, HOLD.
  - IDLE → LOAD on `in_fire`.
  - LOAD → RUN unconditionally.
  - RUN → HOLD when `round==NR`; otherwise RUN and `round` increments.
  - HOLD → IDLE on `out_ready` without `in_fire`; HOLD → LOAD on `out_ready & in_fire` (back-to-back).
- `in_ready` = (IDLE) | (HOLD & `out_ready`). A new request is never accepted while the old result is unconsumed.
- `ke_rst` = 1 only in LOAD.
- `ke_done` = 0 in LOAD and RUN; 1 in IDLE and HOLD. This keeps the round-key output stable outside RUN.
- `st_en` = 1 only in RUN.
- `round`:
  - Cleared to 0 on entry to LOAD.
  - Increments by 1 each RUN cycle, saturating at NR.
  - Holds in HOLD; reads 0 in IDLE and LOAD.
- `first_round` and `last_round` are decoded from `round` and qualified by RUN; they are 0 outside RUN.
- `out_valid` = 1 exactly in HOLD. It holds stable with `round`/`st_en` unchanged until `out_ready`.
- `in_valid` outside the `in_ready` window is ignored; no request is queued.
- Reset:
  - Reset in any state returns to IDLE with `round=0`.
  - Outputs after reset: `in_ready=1`, `out_valid=0`, `ke_rst=0`, `ke_done=1`, `st_en=0`, `busy=0`, `first_round=last_round=0`, `in_fire=in_valid`.
  - Reset mid-RUN discards the block; no `out_valid` is produced for it.
- `round` never exceeds NR; there is no wrap-around.

## Timing
- Request accepted at cycle T (`in_fire`=1).
- T+1: LOAD; key expansion samples `ke_rst`.
- T+2: RUN, `round=0`; key expansion presents round key 0.
- T+3..T+12: RUN, `round`=1..10. The round key presented matches `round` every RUN cycle.
- T+13: HOLD, `out_valid=1`. Total latency from accept to `out_valid` is 13 cycles.
- If `out_ready=1` at T+13 together with a new `in_fire`, the new block's LOAD is at T+14. Sustained throughput is one block per 13 cycles.
- All outputs are registered-state decodes except `in_ready` and `in_fire`, which are combinational from `out_ready`/`in_valid`.

## Structure
- Shared package `aes_pkg` holds:
  - `ctrl_state_t`, a 2-bit enum of IDLE/LOAD/RUN/HOLD;
  - the constants `AES_NR=10` and `AES_RW=4`.
- Single module with no sub-module. The round counter is a plain register inside this module.
- The top-level core instantiates `aes_round_ctrl` next to keyexpansion and wires `ke_rst`→reset and `ke_done`→done.

## Test plan
- Single block, `out_ready=1`, `in_valid` pulsed at T=5 → LOAD at 6, `round` 0..10 over cycles 7..17, `out_valid` only at 18, `busy` 6..18.
- Integration with keyexpansion, key 2b7e151628aed2a6abf7158809cf4f3c:
  - round 0 key equals the key;
  - round 1 key = a0fafe1788542cb123a339392a6c7605;
  - round 10 key = d014f9a8c9ee2589e13f0cc8b6630ca6, stable through a 5-cycle HOLD.
- Backpressure: `out_ready=0` for 20 cycles → `out_valid`, `round=10` and `ke_done=1` held; `in_ready=0` throughout; `in_valid` pulses are ignored.
- Back-to-back: `out_ready=1` with `in_valid=1` in HOLD → `in_fire` in the same cycle, LOAD next cycle, and the second `out_valid` exactly 13 cycles after the first.
- Reset asserted at `round=4` → IDLE next cycle; `out_valid` is never raised; a subsequent request completes normally with 13-cycle latency.
- `in_valid` held high continuously → exactly one acceptance per 13 cycles. `in_fire` is never asserted during LOAD/RUN.
